inv_cell: RTL and testbench
===========================

// Module: inv_cell
// PURPOSE
//  Bit-wise inverter: combinational output Y = ~A, plus a registered copy of
//  the inverted value and a saturating count of registered-output changes.
//  Leaf cell used wherever inverted signals or inverted-signal activity
//  statistics are needed.
//  One clock; reset is asynchronous and active-low (clk, rst_n).
// PARAMETERS
//  WIDTH  1   data width of A / Y / Y_q (>=1)
//  CNT_W  8   width of toggle_cnt (>=1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous reset, active low
//  A           in   WIDTH  data input
//  Y           out  WIDTH  combinational inverse of A
//  Y_q         out  WIDTH  registered inverse of A
//  toggle_cnt  out  CNT_W  number of clock edges on which Y_q changed, saturating
// BEHAVIOUR
//  - Y = ~A bit-wise, purely combinational, zero clock latency.
//  - Y is independent of clk and rst_n; it follows A during reset.
//  - Y_q: on rst_n low, immediately set to all ones (inverse of A = 0).
//  - Y_q: on each rising clk edge with rst_n high, Y_q <= ~A. Latency is 1 cycle.
//  - toggle_cnt: on rst_n low, immediately cleared to 0.
//  - toggle_cnt: on a rising edge with rst_n high, increments by 1 when the
//    next Y_q value differs from the current Y_q value in any bit.
//  - toggle_cnt saturates at 2^CNT_W-1; it never wraps to 0.
//  - Multiple bits changing on the same edge count as one toggle.
//  - Reset asserted mid-operation: Y_q and toggle_cnt clear asynchronously,
//    without waiting for a clock edge.
//  - Reset release: the first edge after release compares ~A with all-ones.
//  - No X propagation from reset. All outputs are driven at all times.
// TESTING
//  - A=0 at t=0, then A=1 at 10ns, A=0 at 20ns, A=1 at 30ns
//    -> Y=1,0,1,0 at those same instants, with no clock dependency.
//  - Hold rst_n=0 with A=1
//    -> Y=0, Y_q=1, toggle_cnt=0.
//    Release reset; on the first edge Y_q becomes 0 and toggle_cnt becomes 1.
//  - Toggle A every clock edge for 4 edges after reset
//    -> Y_q lags ~A by 1 cycle; toggle_cnt counts 1,2,3,4.
//  - Hold A constant for 10 edges
//    -> toggle_cnt unchanged.
//  - CNT_W=2, toggle A for 6 edges
//    -> toggle_cnt counts 1,2,3,3,3,3 (saturates).
//  - WIDTH=4, A=4'b1010
//    -> Y=4'b0101. Next edge: Y_q=4'b0101 and toggle_cnt increments once.
//    Assert rst_n=0 between edges -> Y_q=4'b1111 and toggle_cnt=0 immediately.

Source files
------------

// File: rtl/inv_cell.sv
// Bit-wise inverter with a registered copy of the inverted value and a
// saturating count of the clock edges on which that registered copy changed.
module inv_cell #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic changed;
    logic cnt_full;

    assign Y        = ~A;
    // Any number of differing bits on one edge is a single toggle.
    assign changed  = (Y != Y_q);
    assign cnt_full = (toggle_cnt == {CNT_W{1'b1}});

    // Reset value all-ones mirrors ~A for A == 0, so the first edge after
    // release compares against all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q        <= {WIDTH{1'b1}};
            toggle_cnt <= '0;
        end else begin
            Y_q <= Y;
            if (changed && !cnt_full)
                toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inv_cell.sv
// Bench for inv_cell: three instances (1-bit, 1-bit with 2-bit counter, 4-bit)
// driven from a vector table, with registered results checked via a scoreboard.
module tb_inv_cell;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a1 = 1'b0, a2 = 1'b0;
    logic [3:0] a4 = 4'h0;
    logic       y1, yq1, y2, yq2;
    logic [3:0] y4, yq4;
    logic [7:0] c1, c4;
    logic [1:0] c2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inv_cell #(.WIDTH(1), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .A(a1), .Y(y1), .Y_q(yq1), .toggle_cnt(c1));
    inv_cell #(.WIDTH(1), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .A(a2), .Y(y2), .Y_q(yq2), .toggle_cnt(c2));
    inv_cell #(.WIDTH(4), .CNT_W(8)) u4 (.clk(clk), .rst_n(rst_n), .A(a4), .Y(y4), .Y_q(yq4), .toggle_cnt(c4));

    typedef struct {
        logic       a1;
        logic       a2;
        logic [3:0] a4;
        logic [3:0] y4;
        logic       yq1;
        logic [7:0] c1;
        logic       yq2;
        logic [1:0] c2;
        logic [3:0] yq4;
        logic [7:0] c4;
    } vec_t;

    typedef struct {
        int         step;
        logic       yq1;
        logic [7:0] c1;
        logic       yq2;
        logic [1:0] c2;
        logic [3:0] yq4;
        logic [7:0] c4;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push(input int step, input vec_t v);
        exp_t e;
        e.step = step;
        e.yq1 = v.yq1; e.c1 = v.c1;
        e.yq2 = v.yq2; e.c2 = v.c2;
        e.yq4 = v.yq4; e.c4 = v.c4;
        sb.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, checked just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("s%0d_yq1", e.step), 32'(yq1), 32'(e.yq1));
            chk($sformatf("s%0d_cnt1", e.step), 32'(c1), 32'(e.c1));
            chk($sformatf("s%0d_yq2", e.step), 32'(yq2), 32'(e.yq2));
            chk($sformatf("s%0d_cnt2", e.step), 32'(c2), 32'(e.c2));
            chk($sformatf("s%0d_yq4", e.step), 32'(yq4), 32'(e.yq4));
            chk($sformatf("s%0d_cnt4", e.step), 32'(c4), 32'(e.c4));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // a1 a2 a4 | y4 | yq1 c1 | yq2 c2 | yq4 c4
        tbl[0] = '{1'b1, 1'b1, 4'b1010, 4'b0101, 1'b0, 8'd1, 1'b0, 2'd1, 4'b0101, 8'd1};
        tbl[1] = '{1'b0, 1'b0, 4'b1010, 4'b0101, 1'b1, 8'd2, 1'b1, 2'd2, 4'b0101, 8'd1};
        tbl[2] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 8'd3, 1'b0, 2'd3, 4'b0000, 8'd2};
        tbl[3] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 8'd4, 1'b1, 2'd3, 4'b1111, 8'd3};
        tbl[4] = '{1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0, 8'd5, 1'b0, 2'd3, 4'b1111, 8'd3};
        tbl[5] = '{1'b1, 1'b0, 4'b0101, 4'b1010, 1'b0, 8'd5, 1'b1, 2'd3, 4'b1010, 8'd4};
        tbl[6] = '{1'b1, 1'b0, 4'b0001, 4'b1110, 1'b0, 8'd5, 1'b1, 2'd3, 4'b1110, 8'd5};

        // Combinational path follows A with reset held, no clock dependency.
        #1  chk("comb_y_t0", 32'(y1), 32'd1);
        #9  a1 = 1'b1;
        #1  chk("comb_y_t10", 32'(y1), 32'd0);
        #9  a1 = 1'b0;
        #1  chk("comb_y_t20", 32'(y1), 32'd1);
        #9  a1 = 1'b1;
        #1  chk("comb_y_t30", 32'(y1), 32'd0);

        #5;
        chk("rst_y1", 32'(y1), 32'd0);
        chk("rst_yq1", 32'(yq1), 32'd1);
        chk("rst_cnt1", 32'(c1), 32'd0);
        chk("rst_yq4", 32'(yq4), 32'hF);
        chk("rst_cnt4", 32'(c4), 32'd0);
        a2 = 1'b1;
        a4 = 4'b1010;
        #1 chk("rst_y4", 32'(y4), 32'b0101);

        // Release reset and walk the vector table, one edge per row.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            a1 = tbl[i].a1;
            a2 = tbl[i].a2;
            a4 = tbl[i].a4;
            push(i, tbl[i]);
            #1 chk($sformatf("s%0d_y4", i), 32'(y4), 32'(tbl[i].y4));
        end

        // Hold inputs for 10 edges: nothing may change.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            push(100 + i, tbl[6]);
        end

        // Drain, then assert reset between edges and check the async clear.
        @(posedge clk);
        #2;
        chk("drain", 32'(sb.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_yq4", 32'(yq4), 32'hF);
        chk("mid_rst_cnt4", 32'(c4), 32'd0);
        chk("mid_rst_yq1", 32'(yq1), 32'd1);
        chk("mid_rst_cnt1", 32'(c1), 32'd0);
        chk("mid_rst_cnt2", 32'(c2), 32'd0);
        chk("mid_rst_y4", 32'(y4), 32'b1110);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
